// File: rtl/clkgen_mdiv.sv
// Multi-channel mclk divider array: per-channel shadowed divide ratio, clean stop
// at the low level, phase-aligned restart and a per-period rising-edge pulse.
module clkgen_mdiv #(
  parameter int unsigned NCH = 4,
  parameter int unsigned WD  = 8
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic [NCH*WD-1:0] cfg_div_ratio,
  input  logic [NCH-1:0]    cfg_ch_en,
  input  logic              cfg_sync_start,
  output logic [NCH-1:0]    clk_o,
  output logic [NCH-1:0]    clk_pls_o,
  output logic [NCH-1:0]    ch_active_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t         r_state     [NCH];
  state_t         w_state_nx  [NCH];
  logic [WD:0]    r_cnt       [NCH];
  logic [WD:0]    w_cnt_nx    [NCH];
  logic [WD-1:0]  r_shadow    [NCH];
  logic [WD-1:0]  w_shadow_nx [NCH];
  logic [WD-1:0]  w_cfg_ratio [NCH];
  logic [WD+1:0]  w_high      [NCH];
  logic [NCH-1:0] w_wrap;
  logic [NCH-1:0] w_clk_nx;
  logic [NCH-1:0] w_pls_nx;
  logic [NCH-1:0] w_act_nx;

  // Outputs are registered from the next-state values so they line up with the
  // state they describe while staying pure flops.
  always_comb begin
    w_wrap   = '0;
    w_clk_nx = '0;
    w_pls_nx = '0;
    w_act_nx = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_cfg_ratio[i] = cfg_div_ratio[i*WD +: WD];
      w_state_nx[i]  = r_state[i];
      w_cnt_nx[i]    = r_cnt[i];
      w_shadow_nx[i] = r_shadow[i];
      w_wrap[i]      = (r_cnt[i] == ({1'b0, r_shadow[i]} + (WD+1)'(1)));

      if (cfg_sync_start && cfg_ch_en[i]) begin
        w_state_nx[i]  = ST_RUN;
        w_cnt_nx[i]    = '0;
        w_shadow_nx[i] = w_cfg_ratio[i];
      end else begin
        case (r_state[i])
          ST_IDLE: begin
            if (cfg_ch_en[i]) begin
              w_state_nx[i]  = ST_RUN;
              w_cnt_nx[i]    = '0;
              w_shadow_nx[i] = w_cfg_ratio[i];
            end
          end
          ST_RUN: begin
            // Enable is only looked at on the wrap edge, so periods are never cut short.
            if (w_wrap[i]) begin
              w_cnt_nx[i] = '0;
              if (cfg_ch_en[i]) begin
                w_shadow_nx[i] = w_cfg_ratio[i];
              end else begin
                w_state_nx[i] = ST_IDLE;
              end
            end else begin
              w_cnt_nx[i] = r_cnt[i] + (WD+1)'(1);
            end
          end
          default: begin
            w_state_nx[i] = ST_IDLE;
            w_cnt_nx[i]   = '0;
          end
        endcase
      end

      // High phase is ceil(D/2) with D = R + 2, i.e. (R + 3) >> 1.
      w_high[i]   = ({2'b00, w_shadow_nx[i]} + (WD+2)'(3)) >> 1;
      w_act_nx[i] = (w_state_nx[i] == ST_RUN);
      w_clk_nx[i] = w_act_nx[i] && ({1'b0, w_cnt_nx[i]} < w_high[i]);
      w_pls_nx[i] = w_act_nx[i] && (w_cnt_nx[i] == '0);
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_state[i]  <= ST_IDLE;
        r_cnt[i]    <= '0;
        r_shadow[i] <= '0;
      end
      clk_o       <= '0;
      clk_pls_o   <= '0;
      ch_active_o <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_state[i]  <= w_state_nx[i];
        r_cnt[i]    <= w_cnt_nx[i];
        r_shadow[i] <= w_shadow_nx[i];
      end
      clk_o       <= w_clk_nx;
      clk_pls_o   <= w_pls_nx;
      ch_active_o <= w_act_nx;
    end
  end

endmodule

// File: tb/tb_clkgen_mdiv.sv
// Self-checking bench for clkgen_mdiv: integer period model plus directed phase checks.
module tb_clkgen_mdiv;
  localparam int NCH = 4;
  localparam int WD  = 8;

  logic              mclk = 1'b0;
  logic              reset;
  logic [NCH*WD-1:0] cfg_div_ratio;
  logic [NCH-1:0]    cfg_ch_en;
  logic              cfg_sync_start;
  logic [NCH-1:0]    clk_o;
  logic [NCH-1:0]    clk_pls_o;
  logic [NCH-1:0]    ch_active_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: per channel, running flag, position within the period and period length.
  int m_act [NCH];
  int m_pos [NCH];
  int m_per [NCH];

  clkgen_mdiv #(.NCH(NCH), .WD(WD)) dut (
    .mclk          (mclk),
    .reset         (reset),
    .cfg_div_ratio (cfg_div_ratio),
    .cfg_ch_en     (cfg_ch_en),
    .cfg_sync_start(cfg_sync_start),
    .clk_o         (clk_o),
    .clk_pls_o     (clk_pls_o),
    .ch_active_o   (ch_active_o)
  );

  always #5 mclk = ~mclk;

  task automatic step();
    @(posedge mclk);
    for (int i = 0; i < NCH; i++) begin
      int r;
      r = int'(cfg_div_ratio[i*WD +: WD]);
      if (reset) begin
        m_act[i] = 0; m_pos[i] = 0; m_per[i] = 2;
      end else if (cfg_sync_start && cfg_ch_en[i]) begin
        m_act[i] = 1; m_pos[i] = 0; m_per[i] = r + 2;
      end else if (m_act[i] == 0) begin
        if (cfg_ch_en[i]) begin
          m_act[i] = 1; m_pos[i] = 0; m_per[i] = r + 2;
        end
      end else if (m_pos[i] == m_per[i] - 1) begin
        m_pos[i] = 0;
        if (cfg_ch_en[i]) m_per[i] = r + 2;
        else m_act[i] = 0;
      end else begin
        m_pos[i] = m_pos[i] + 1;
      end
    end
    #1;
  endtask

  function automatic logic [3*NCH-1:0] model_vec();
    logic [NCH-1:0] c, p, a;
    for (int i = 0; i < NCH; i++) begin
      a[i] = (m_act[i] != 0);
      c[i] = a[i] && (m_pos[i] < (m_per[i] + 1) / 2);
      p[i] = a[i] && (m_pos[i] == 0);
    end
    return {c, p, a};
  endfunction

  task automatic set_ratio(input int ch, input int r);
    logic [WD-1:0] v;
    v = r[WD-1:0];
    cfg_div_ratio[ch*WD +: WD] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1; cfg_ch_en = '0; cfg_sync_start = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_ch_en = 4'b1111; cfg_sync_start = 1'b1;
    cfg_div_ratio = $urandom;
    step();
    n_cmp++;
    if ({clk_o, clk_pls_o, ch_active_o} !== 12'h000) begin
      n_bad++; $display("FAIL reset_outputs got %h exp %h", {clk_o, clk_pls_o, ch_active_o}, 12'h000);
    end
    cfg_sync_start = 1'b0;
    step();
    n_cmp++;
    if ({clk_o, clk_pls_o, ch_active_o} !== model_vec()) begin
      n_bad++; $display("FAIL reset_hold got %h exp %h", {clk_o, clk_pls_o, ch_active_o}, model_vec());
    end
  endtask

  task automatic test_ratios();
    int pc [NCH], hi [NCH], len [NCH];
    int exp_hi [NCH], exp_lo [NCH];
    exp_hi = '{1, 2, 3, 129};
    exp_lo = '{1, 1, 3, 128};
    do_reset();
    set_ratio(0, 0); set_ratio(1, 1); set_ratio(2, 4); set_ratio(3, 255);
    cfg_ch_en = 4'b1111;
    for (int i = 0; i < NCH; i++) begin pc[i] = 0; hi[i] = 0; len[i] = 0; end
    for (int k = 0; k < 600; k++) begin
      step();
      n_cmp++;
      if ({clk_o, clk_pls_o, ch_active_o} !== model_vec()) begin
        n_bad++; $display("FAIL ratios cyc %0d got %h exp %h", k, {clk_o, clk_pls_o, ch_active_o}, model_vec());
      end
      for (int i = 0; i < NCH; i++) begin
        if (clk_pls_o[i] === 1'b1) pc[i]++;
        if (pc[i] == 1) begin len[i]++; hi[i] += int'(clk_o[i]); end
      end
    end
    for (int i = 0; i < NCH; i++) begin
      n_cmp++;
      if (hi[i] != exp_hi[i]) begin
        n_bad++; $display("FAIL high_phase ch%0d got %0d exp %0d", i, hi[i], exp_hi[i]);
      end
      n_cmp++;
      if (len[i] - hi[i] != exp_lo[i]) begin
        n_bad++; $display("FAIL low_phase ch%0d got %0d exp %0d", i, len[i] - hi[i], exp_lo[i]);
      end
    end
  endtask

  task automatic test_ratio_change();
    int pulses [$];
    int exp_p [4];
    exp_p = '{5, 9, 13, 17};
    do_reset();
    cfg_div_ratio = '0;
    set_ratio(0, 4); cfg_ch_en = 4'b0001;
    step();  // cnt = 0
    step();  // cnt = 1
    set_ratio(0, 2);
    for (int k = 1; k <= 20; k++) begin
      step();
      n_cmp++;
      if ({clk_o, clk_pls_o, ch_active_o} !== model_vec()) begin
        n_bad++; $display("FAIL ratio_change cyc %0d got %h exp %h", k, {clk_o, clk_pls_o, ch_active_o}, model_vec());
      end
      if (clk_pls_o[0] === 1'b1) pulses.push_back(k);
    end
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (pulses.size() <= j || pulses[j] != exp_p[j]) begin
        n_bad++; $display("FAIL ratio_change_pulse %0d got %0d exp %0d", j,
                          (pulses.size() > j) ? pulses[j] : -1, exp_p[j]);
      end
    end
  endtask

  task automatic test_disable();
    int act_cyc, gaps;
    do_reset();
    cfg_div_ratio = '0;
    set_ratio(2, 4); cfg_ch_en = 4'b0100;
    step();  // cnt = 0
    cfg_ch_en = 4'b0000;
    act_cyc = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++;
      if ({clk_o, clk_pls_o, ch_active_o} !== model_vec()) begin
        n_bad++; $display("FAIL disable cyc %0d got %h exp %h", k, {clk_o, clk_pls_o, ch_active_o}, model_vec());
      end
      act_cyc += int'(ch_active_o[2]);
    end
    n_cmp++;
    if (act_cyc != 5) begin
      n_bad++; $display("FAIL disable_tail got %0d exp %0d", act_cyc, 5);
    end
    cfg_ch_en = 4'b0100;
    step(); step();
    cfg_ch_en = 4'b0000;
    step(); step();
    cfg_ch_en = 4'b0100;
    gaps = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      n_cmp++;
      if ({clk_o, clk_pls_o, ch_active_o} !== model_vec()) begin
        n_bad++; $display("FAIL reenable cyc %0d got %h exp %h", k, {clk_o, clk_pls_o, ch_active_o}, model_vec());
      end
      if (ch_active_o[2] !== 1'b1) gaps++;
    end
    n_cmp++;
    if (gaps != 0) begin
      n_bad++; $display("FAIL reenable_gap got %0d exp %0d", gaps, 0);
    end
  endtask

  task automatic test_sync();
    do_reset();
    for (int i = 0; i < NCH; i++) set_ratio(i, $urandom_range(1, 20));
    cfg_ch_en = 4'b1111;
    for (int rep = 0; rep < 2; rep++) begin
      repeat ($urandom_range(5, 40)) begin
        step();
        n_cmp++;
        if ({clk_o, clk_pls_o, ch_active_o} !== model_vec()) begin
          n_bad++; $display("FAIL sync_pre got %h exp %h", {clk_o, clk_pls_o, ch_active_o}, model_vec());
        end
      end
      cfg_sync_start = 1'b1;
      step();
      cfg_sync_start = 1'b0;
      n_cmp++;
      if ({clk_pls_o[2:0], clk_o[2:0]} !== 6'b111111 ||
          (rep == 0 && {clk_pls_o[3], clk_o[3]} !== 2'b11)) begin
        n_bad++; $display("FAIL sync_align rep %0d got pls %b clk %b", rep, clk_pls_o, clk_o);
      end
      n_cmp++;
      if ({clk_o, clk_pls_o, ch_active_o} !== model_vec()) begin
        n_bad++; $display("FAIL sync_model rep %0d got %h exp %h", rep, {clk_o, clk_pls_o, ch_active_o}, model_vec());
      end
      repeat (30) begin
        step();
        n_cmp++;
        if ({clk_o, clk_pls_o, ch_active_o} !== model_vec()) begin
          n_bad++; $display("FAIL sync_post got %h exp %h", {clk_o, clk_pls_o, ch_active_o}, model_vec());
        end
      end
      cfg_ch_en = 4'b0111;
    end
  endtask

  task automatic test_sync_wrap();
    logic [5:0] seq;
    do_reset();
    cfg_div_ratio = '0;
    set_ratio(0, 3); cfg_ch_en = 4'b0001;
    step();                  // cnt = 0
    repeat (4) step();       // cnt = 4 = D-1
    set_ratio(0, 0);
    cfg_sync_start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      cfg_sync_start = 1'b0;
      seq[5-k] = clk_o[0];
      n_cmp++;
      if ({clk_o, clk_pls_o, ch_active_o} !== model_vec()) begin
        n_bad++; $display("FAIL sync_wrap cyc %0d got %h exp %h", k, {clk_o, clk_pls_o, ch_active_o}, model_vec());
      end
    end
    n_cmp++;
    if (seq !== 6'b101010) begin
      n_bad++; $display("FAIL sync_wrap_seq got %b exp %b", seq, 6'b101010);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < NCH; i++) set_ratio(i, $urandom_range(2, 30));
    cfg_ch_en = 4'b1111;
    repeat ($urandom_range(10, 40)) step();
    reset = 1'b1;
    step();
    n_cmp++;
    if ({clk_o, clk_pls_o, ch_active_o} !== 12'h000) begin
      n_bad++; $display("FAIL reset_mid got %h exp %h", {clk_o, clk_pls_o, ch_active_o}, 12'h000);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({clk_o, clk_pls_o, ch_active_o} !== 12'hFFF) begin
      n_bad++; $display("FAIL reset_restart got %h exp %h", {clk_o, clk_pls_o, ch_active_o}, 12'hFFF);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 29) == 0) set_ratio(i, ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 12));
        if ($urandom_range(0, 19) == 0) cfg_ch_en[i] = ~cfg_ch_en[i];
      end
      cfg_sync_start = ($urandom_range(0, 39) == 0);
      reset          = ($urandom_range(0, 299) == 0);
      step();
      n_cmp++;
      if ({clk_o, clk_pls_o, ch_active_o} !== model_vec()) begin
        n_bad++; $display("FAIL random cyc %0d got %h exp %h", k, {clk_o, clk_pls_o, ch_active_o}, model_vec());
      end
    end
    reset = 1'b0; cfg_sync_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_div_ratio = '0; cfg_ch_en = '0; cfg_sync_start = 1'b0;
    for (int i = 0; i < NCH; i++) begin m_act[i] = 0; m_pos[i] = 0; m_per[i] = 2; end
    test_reset();
    test_ratios();
    test_ratio_change();
    test_disable();
    test_sync();
    test_sync_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
